// File: rtl/l2_bs_arbiter.sv
// Banked-store port arbiter: merges refill and sourceD writes onto one store write port
// and passes sourceD reads through with a same-set hazard stall. Optional macro: L2_BS_ARB_STARVE_EN.
`ifndef WAY_BITS
`define WAY_BITS 3
`endif
`ifndef SET_BITS
`define SET_BITS 8
`endif
`ifndef OUTER_MASK_BITS
`define OUTER_MASK_BITS 8
`endif
`ifndef INNER_MASK_BITS
`define INNER_MASK_BITS 4
`endif
`ifndef L2CACHE_BEATBYTES
`define L2CACHE_BEATBYTES 8
`endif

module l2_bs_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               rf_valid_i,
  output logic                               rf_ready_o,
  input  logic [`WAY_BITS-1:0]               rf_way_i,
  input  logic [`SET_BITS-1:0]               rf_set_i,
  input  logic [`OUTER_MASK_BITS-1:0]        rf_mask_i,
  input  logic [`L2CACHE_BEATBYTES*8-1:0]    rf_data_i,
  input  logic                               sw_valid_i,
  output logic                               sw_ready_o,
  input  logic [`WAY_BITS-1:0]               sw_way_i,
  input  logic [`SET_BITS-1:0]               sw_set_i,
  input  logic [`INNER_MASK_BITS-1:0]        sw_mask_i,
  input  logic [`L2CACHE_BEATBYTES*8-1:0]    sw_data_i,
  input  logic                               rd_valid_i,
  output logic                               rd_ready_o,
  input  logic [`WAY_BITS-1:0]               rd_way_i,
  input  logic [`SET_BITS-1:0]               rd_set_i,
  output logic                               bs_w_valid_o,
  output logic [`WAY_BITS-1:0]               bs_w_way_o,
  output logic [`SET_BITS-1:0]               bs_w_set_o,
  output logic [((`INNER_MASK_BITS > `OUTER_MASK_BITS) ? `INNER_MASK_BITS : `OUTER_MASK_BITS)-1:0] bs_w_mask_o,
  output logic [`L2CACHE_BEATBYTES*8-1:0]    bs_w_data_o,
  output logic                               bs_r_valid_o,
  output logic [`WAY_BITS-1:0]               bs_r_way_o,
  output logic [`SET_BITS-1:0]               bs_r_set_o,
  output logic                               rd_resp_valid_o,
  output logic [`WAY_BITS-1:0]               rd_resp_way_o
);

  localparam int MASK_W = (`INNER_MASK_BITS > `OUTER_MASK_BITS) ? `INNER_MASK_BITS : `OUTER_MASK_BITS;

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("l2_bs_arbiter: STARVE_MAX must lie in 1..15");
  end

  logic force_sw;
  logic rf_grant;
  logic sw_grant;
  logic rd_hazard;

`ifdef L2_BS_ARB_STARVE_EN
  logic [3:0] starve_cnt;

  assign force_sw = (starve_cnt == 4'(STARVE_MAX));

  // Counts consecutive cycles sourceD waited; saturates so force_sw holds until sw wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!sw_valid_i || sw_grant) begin
      starve_cnt <= '0;
    end else if (!force_sw) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign force_sw = 1'b0;
`endif

  assign rf_ready_o = !(force_sw && sw_valid_i);
  assign sw_ready_o = !rf_valid_i || force_sw;
  assign rf_grant   = rf_valid_i && rf_ready_o;
  assign sw_grant   = sw_valid_i && sw_ready_o;

  // The ready terms already make the two grants mutually exclusive.
  always_comb begin
    bs_w_valid_o = rf_grant || sw_grant;
    if (rf_grant) begin
      bs_w_way_o  = rf_way_i;
      bs_w_set_o  = rf_set_i;
      bs_w_mask_o = MASK_W'(rf_mask_i);
      bs_w_data_o = rf_data_i;
    end else begin
      bs_w_way_o  = sw_way_i;
      bs_w_set_o  = sw_set_i;
      bs_w_mask_o = MASK_W'(sw_mask_i);
      bs_w_data_o = sw_data_i;
    end
  end

  assign rd_hazard    = bs_w_valid_o && (rd_set_i == bs_w_set_o);
  assign rd_ready_o   = !rd_hazard;
  assign bs_r_valid_o = rd_valid_i && rd_ready_o;
  assign bs_r_way_o   = rd_way_i;
  assign bs_r_set_o   = rd_set_i;

  // The store returns read data one cycle after the access is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_resp_valid_o <= 1'b0;
      rd_resp_way_o   <= '0;
    end else begin
      rd_resp_valid_o <= bs_r_valid_o;
      if (bs_r_valid_o) begin
        rd_resp_way_o <= rd_way_i;
      end
    end
  end

endmodule
